// File: rtl/cart_rom_upload.sv
// Cartridge ROM upload reader: serves HPS ioctl reads from SDRAM ch0
// through a one-byte prefetch buffer so sequential reads never stall.
module cart_rom_upload #(
    parameter logic [7:0]  FILL_BYTE    = 8'hFF,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        upload_en,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic [18:0] rom_last,
    output logic [18:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_busy,
    output logic        active
);
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, SERVE} state_t;

    state_t           state, state_d;
    logic             upload_q;
    logic [18:0]      target, target_d, pend_addr, pend_addr_d, buf_addr, buf_addr_d;
    logic             demand, demand_d, pending, pending_d, buf_valid, buf_valid_d;
    logic             drain, drain_d, restart, restart_d;
    logic [7:0]       rbuf, rbuf_d, din_d;
    logic             wait_d;
    logic [CNT_W-1:0] tmo, tmo_d;

    logic        rise, fall, draining, rd_ok, in_range, buf_hit, done;
    logic [18:0] rd_addr, rd_next;

    assign rise     = upload_en && !upload_q;
    assign fall     = !upload_en && upload_q;
    assign draining = drain || fall;
    assign rd_addr  = ioctl_addr[18:0];
    assign rd_next  = rd_addr + 19'd1;
    assign in_range = (ioctl_addr[24:19] == '0) && (rd_addr <= rom_last);
    assign buf_hit  = buf_valid && (buf_addr == rd_addr);
    assign done     = (state == WAIT_LO) && !mem_busy;
    assign rd_ok    = ioctl_rd && !ioctl_wait && !draining && (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d     = state;
        target_d    = target;
        demand_d    = demand;
        pending_d   = pending;
        pend_addr_d = pend_addr;
        rbuf_d      = rbuf;
        buf_addr_d  = buf_addr;
        buf_valid_d = buf_valid;
        din_d       = ioctl_din;
        wait_d      = ioctl_wait;
        tmo_d       = tmo;
        drain_d     = drain;
        restart_d   = restart;

        case (state)
            IDLE: if (upload_en && (rise || restart)) begin
                state_d  = ISSUE;
                target_d = '0;
                demand_d = 1'b0;
            end
            ISSUE: if (!mem_busy) begin
                state_d = WAIT_HI;
                tmo_d   = '0;
            end
            WAIT_HI: begin
                if (mem_busy || tmo == CNT_W'(BUSY_TIMEOUT - 1)) state_d = WAIT_LO;
                else                                            tmo_d   = tmo + 1'b1;
            end
            WAIT_LO: if (!mem_busy) begin
                if (draining) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d      = mem_dout;
                    buf_addr_d  = target;
                    buf_valid_d = 1'b1;
                    if (demand) begin
                        din_d    = mem_dout;
                        wait_d   = 1'b0;
                        demand_d = 1'b0;
                        if (target == rom_last) begin
                            state_d = SERVE;
                        end else begin
                            target_d = target + 19'd1;
                            state_d  = ISSUE;
                        end
                    end else if (pending) begin
                        target_d  = pend_addr;
                        demand_d  = 1'b1;
                        pending_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: if (draining) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Host read is resolved after the memory side so that a read landing on
        // the completion cycle can reuse or redirect the finishing access.
        if (rd_ok) begin
            if (!in_range) begin
                din_d = FILL_BYTE;
            end else if (buf_hit) begin
                din_d = rbuf;
                if (state == SERVE && rd_addr != rom_last) begin
                    target_d = rd_next;
                    demand_d = 1'b0;
                    state_d  = ISSUE;
                end
            end else if (state != SERVE && rd_addr == target) begin
                if (done) begin
                    din_d = mem_dout;
                    if (rd_addr != rom_last) begin
                        target_d = rd_next;
                        state_d  = ISSUE;
                    end
                end else begin
                    demand_d = 1'b1;
                    wait_d   = 1'b1;
                end
            end else begin
                wait_d = 1'b1;
                if (state == SERVE || done) begin
                    target_d = rd_addr;
                    demand_d = 1'b1;
                    state_d  = ISSUE;
                end else begin
                    pending_d   = 1'b1;
                    pend_addr_d = rd_addr;
                end
            end
        end

        if (fall && state != IDLE) begin
            wait_d      = 1'b0;
            buf_valid_d = 1'b0;
            pending_d   = 1'b0;
            demand_d    = 1'b0;
            drain_d     = 1'b1;
        end
        if (state_d == IDLE) drain_d = 1'b0;

        if (state == IDLE) restart_d = 1'b0;
        else if (rise)     restart_d = 1'b1;
        else if (fall)     restart_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            upload_q   <= 1'b0;
            target     <= '0;
            demand     <= 1'b0;
            pending    <= 1'b0;
            pend_addr  <= '0;
            rbuf       <= '0;
            buf_addr   <= '0;
            buf_valid  <= 1'b0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            tmo        <= '0;
            drain      <= 1'b0;
            restart    <= 1'b0;
        end else begin
            upload_q   <= upload_en;
            target     <= target_d;
            demand     <= demand_d;
            pending    <= pending_d;
            pend_addr  <= pend_addr_d;
            rbuf       <= rbuf_d;
            buf_addr   <= buf_addr_d;
            buf_valid  <= buf_valid_d;
            ioctl_din  <= din_d;
            ioctl_wait <= wait_d;
            tmo        <= tmo_d;
            drain      <= drain_d;
            restart    <= restart_d;
        end
    end

    always_comb begin
        mem_rd   = (state == ISSUE);
        mem_addr = (state == ISSUE) ? target : '0;
        active   = (state != IDLE);
    end
endmodule

// File: doc/cart_rom_upload.md
Name: cart_rom_upload

Overview:
- Reader end of the cartridge ROM path. It services HPS ioctl upload requests by reading bytes back from the SDRAM cart channel.
- It is the opposite direction of the ROM download/write path. It sits beside the SDRAM arbiter in clk_sys and shares ch0 with the core when the core is held in reset.
- A one-byte prefetch buffer keeps ioctl_wait low for sequential reads.

Parameters:
- FILL_BYTE, 8'hFF: value returned for addresses beyond the loaded ROM.
- BUSY_TIMEOUT, 8: clk_sys cycles to wait for mem_busy to rise after a request before treating the access as complete.

Ports:
- clk_sys  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- upload_en  in  1  ioctl upload active for the cart index.
- ioctl_rd  in  1  one-cycle HPS read strobe.
- ioctl_addr  in  25  byte address of the read.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  high while ioctl_din is not yet valid for the last ioctl_rd.
- rom_last  in  19  address of last loaded ROM byte (rom_mask).
- mem_addr  out  19  SDRAM ch0 read address.
- mem_rd  out  1  SDRAM ch0 read request.
- mem_dout  in  8  SDRAM ch0 read data.
- mem_busy  in  1  SDRAM ch0 busy.
- active  out  1  high from upload_en rise until upload_en fall and no transaction outstanding.

Behaviour:
- Reset values: all outputs 0; buffer invalid; state IDLE. Reset wins over every other event, including mid-transaction. No memory abort is issued; the SDRAM side is reset by its own init.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, SERVE.
- IDLE: on upload_en rising edge, target address = 0, demand flag = 0 (prefetch), go to ISSUE; active <= 1.
- ISSUE:
  - Hold mem_rd=1 and mem_addr=target until a cycle with mem_busy=0.
  - That cycle is acceptance: next cycle mem_rd=0, go to WAIT_HI.
- WAIT_HI:
  - Wait for mem_busy=1, then go to WAIT_LO.
  - If BUSY_TIMEOUT cycles elapse without it, go to WAIT_LO anyway (counter 0..BUSY_TIMEOUT-1, saturating).
- WAIT_LO:
  - On first cycle with mem_busy=0: buf <= mem_dout, buf_addr <= target, buf valid.
  - If demand flag set: ioctl_din <= mem_dout, ioctl_wait <= 0, then prefetch target+1 (19-bit wrap; skip the prefetch if target == rom_last).
  - Otherwise go to SERVE.
- SERVE (idle with buffer): handle ioctl_rd as follows.
  - Out of range (ioctl_addr[24:19] != 0 or ioctl_addr[18:0] > rom_last): next cycle ioctl_din <= FILL_BYTE, ioctl_wait stays 0, no memory access.
  - Hit (buf valid, buf_addr == ioctl_addr[18:0]): next cycle ioctl_din <= buf, ioctl_wait 0, then prefetch ioctl_addr+1 (unless it equals rom_last+1), with demand flag 0.
  - Miss: ioctl_wait <= 1 the cycle after ioctl_rd. Target = ioctl_addr, demand = 1, go to ISSUE.
- ioctl_rd during a prefetch:
  - Hit on the in-flight target: set demand=1 and ioctl_wait=1. The data is delivered when the prefetch completes.
  - Miss: set ioctl_wait=1 and latch a pending address. After the prefetch completes, issue the pending address as a demand read.
- ioctl_rd while ioctl_wait=1 is ignored.
- Latency:
  - Hit: data valid 1 cycle after ioctl_rd.
  - Miss: ioctl_wait deasserts in the same cycle ioctl_din updates, i.e. one cycle after WAIT_LO sees mem_busy=0.
- upload_en fall:
  - Any outstanding memory transaction runs to WAIT_LO completion; its data is discarded.
  - ioctl_wait <= 0 immediately; buffer invalidated.
  - active drops the cycle the state returns to IDLE.
  - A new upload_en rise during drain is honoured after IDLE is reached.
- rom_last change while active: compares use the live value; the buffer is not invalidated.

Test Plan:
- Load SDRAM model bytes 0..3 = 11,22,33,44; rom_last=3. Raise upload_en, then ioctl_rd addr 0 after active settles -> ioctl_din=11 one cycle later, ioctl_wait never high. Sequential rd 1,2,3 -> 22,33,44, each 1-cycle latency.
- ioctl_rd addr 2 right after upload_en (buffer holds 0) -> ioctl_wait=1 the next cycle; demand read at mem_addr=2; ioctl_din=33 with ioctl_wait=0 after mem_busy falls.
- rom_last=3, ioctl_rd addr 4 and addr 25'h80000 -> ioctl_din=FF the next cycle, mem_rd never asserted.
- SDRAM model never raises mem_busy -> access completes after 8 cycles in WAIT_HI; data is latched and no hang occurs.
- Drop upload_en while in WAIT_HI -> ioctl_wait=0 immediately; active falls after mem_busy falls; a later ioctl_rd hit does not return the stale buffer (forces a miss).
- Assert reset in WAIT_LO -> next cycle all outputs 0, state IDLE; a subsequent upload_en rise restarts from addr 0.
